// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 8-bit LCD controller:
//   - lcd_state_t    : controller FSM states
//   - LCD_* commands : HD44780 instruction codes used by the init sequence
//   - CHR_* codes    : ASCII codes for upstream formatters (digits, sign, blank)
//   - init_cmd()     : init ROM lookup (FUNCSET x reps, display on, clear, entry)
//   - is_long_low()  : true for commands that need the long EN-low settle time
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP   = 3'd0,
    INIT_HI = 3'd1,
    INIT_LO = 3'd2,
    IDLE    = 3'd3,
    WR_HI   = 3'd4,
    WR_LO   = 3'd5
  } lcd_state_t;

  localparam logic [7:0] LCD_FUNCSET_8B2L      = 8'h38;
  localparam logic [7:0] LCD_DISP_ON_CUR_BLINK = 8'h0F;
  localparam logic [7:0] LCD_CLEAR             = 8'h01;
  localparam logic [7:0] LCD_ENTRY_INC         = 8'h06;

  localparam logic [7:0] CHR_SPACE  = 8'h20;
  localparam logic [7:0] CHR_MINUS  = 8'h2D;
  localparam logic [7:0] CHR_PLUS   = 8'h2B;
  localparam logic [7:0] CHR_DIGIT0 = 8'h30;

  // Init ROM: 'reps' function-set commands, then display-on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [31:0] idx, input logic [31:0] reps);
    logic [7:0] cmd;
    if (idx < reps) begin
      cmd = LCD_FUNCSET_8B2L;
    end else begin
      case (idx - reps)
        32'd0:   cmd = LCD_DISP_ON_CUR_BLINK;
        32'd1:   cmd = LCD_CLEAR;
        default: cmd = LCD_ENTRY_INC;
      endcase
    end
    return cmd;
  endfunction

  // Clear (0x01) and home (0x02/0x03) execute slowly inside the panel.
  function automatic logic is_long_low(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_wr_fifo.sv
// -----------------------------------------------------------------------------
// lcd_wr_fifo
// Synchronous first-word-fall-through FIFO for queued LCD writes ({rs,data}).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (flushes the FIFO)
//   push, push_data : write request/data (ignored while full)
//   pop, pop_data   : read request (ignored while empty); pop_data shows head
//   full, empty     : status from the registered occupancy
//   level           : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module lcd_wr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head is visible combinationally so the controller can load it on the pop edge.
  assign pop_data = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_hd44780_ctrl
// HD44780 8-bit LCD controller: power-up wait, autonomous init sequence, then
// issues queued command/character writes as timed EN strobes.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   wr_valid/wr_ready   : upstream write handshake (accepted when both high)
//   wr_rs, wr_data      : 0 = command, 1 = character; 8-bit code
//   init_done           : sticky flag, set when init sequence completes
//   busy                : controller not idle or FIFO holds pending writes
//   fifo_level          : FIFO occupancy
//   RS, RW, EN, data    : LCD bus (RW always 0, write only)
// -----------------------------------------------------------------------------
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC    = 2250000,
  parameter int unsigned EN_HIGH_CYC  = 125000,
  parameter int unsigned EN_LOW_CYC   = 250000,
  parameter int unsigned CLR_LOW_CYC  = 250000,
  parameter int unsigned FUNCSET_REPS = 4,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic                              wr_rs,
  input  logic [7:0]                        wr_data,
  output logic                              init_done,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              RS,
  output logic                              RW,
  output logic                              EN,
  output logic [7:0]                        data
);

  localparam logic [31:0] INIT_LAST = 32'(FUNCSET_REPS + 2);

  if (PWRUP_CYC == 0 || EN_HIGH_CYC == 0 || EN_LOW_CYC == 0 || CLR_LOW_CYC == 0) begin : g_bad_timing
    $error("lcd_hd44780_ctrl: all cycle-count parameters must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_hd44780_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  lcd_state_t  state_reg;
  logic [31:0] cnt_reg;
  logic [31:0] idx_reg;
  logic        rs_reg;
  logic [7:0]  data_reg;
  logic        en_reg;
  logic        init_done_reg;

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [8:0]  fifo_head;
  logic [31:0] low_last;

  assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

  lcd_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (wr_valid && wr_ready),
    .push_data ({wr_rs, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // RS/data are held through the low phase, so they select its length.
  assign low_last = is_long_low(rs_reg, data_reg) ? (CLR_LOW_CYC - 32'd1) : (EN_LOW_CYC - 32'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= PWRUP;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      rs_reg        <= 1'b0;
      data_reg      <= 8'h00;
      en_reg        <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        PWRUP: begin
          if (cnt_reg == PWRUP_CYC - 32'd1) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rs_reg    <= 1'b0;
            data_reg  <= init_cmd(32'd0, FUNCSET_REPS);
            en_reg    <= 1'b1;
            state_reg <= INIT_HI;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        INIT_HI, WR_HI: begin
          if (cnt_reg == EN_HIGH_CYC - 32'd1) begin
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
            state_reg <= (state_reg == INIT_HI) ? INIT_LO : WR_LO;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        INIT_LO: begin
          if (cnt_reg == low_last) begin
            cnt_reg <= '0;
            if (idx_reg == INIT_LAST) begin
              init_done_reg <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              idx_reg   <= idx_reg + 32'd1;
              rs_reg    <= 1'b0;
              data_reg  <= init_cmd(idx_reg + 32'd1, FUNCSET_REPS);
              en_reg    <= 1'b1;
              state_reg <= INIT_HI;
            end
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        WR_LO: begin
          if (cnt_reg == low_last) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        IDLE: begin
          if (!fifo_empty) begin
            rs_reg    <= fifo_head[8];
            data_reg  <= fifo_head[7:0];
            en_reg    <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= WR_HI;
          end
        end
        default: begin
          state_reg <= PWRUP;
          cnt_reg   <= '0;
          en_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready  = !fifo_full;
  assign busy      = (state_reg != IDLE) || !fifo_empty;
  assign init_done = init_done_reg;
  assign RS        = rs_reg;
  assign RW        = 1'b0;
  assign EN        = en_reg;
  assign data      = data_reg;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_hd44780_ctrl
// Self-checking bench. The reference model tracks the panel schedule in edge
// numbers: strobe start edge, EN-high span and low span from the command rules,
// plus a queue of accepted writes. Every cycle the bus and status are compared.
// -----------------------------------------------------------------------------
module tb_lcd_hd44780_ctrl;

  localparam int PWR   = 20;
  localparam int HI    = 4;
  localparam int LO    = 8;
  localparam int CLR   = 16;
  localparam int REPS  = 4;
  localparam int DEPTH = 4;
  localparam int NINIT = REPS + 3;

  logic       CLK;
  logic       RST;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       init_done;
  logic       busy;
  logic [2:0] fifo_level;
  logic       RS;
  logic       RW;
  logic       EN;
  logic [7:0] data;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC    (PWR),
    .EN_HIGH_CYC  (HI),
    .EN_LOW_CYC   (LO),
    .CLR_LOW_CYC  (CLR),
    .FUNCSET_REPS (REPS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_rs      (wr_rs),
    .wr_data    (wr_data),
    .init_done  (init_done),
    .busy       (busy),
    .fifo_level (fifo_level),
    .RS         (RS),
    .RW         (RW),
    .EN         (EN),
    .data       (data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (edge numbers count posedges since reset release)
  int         e;
  int         idle_at;
  int         init_end;
  int         cur_start;
  logic [8:0] cur_val;
  int         init_i;
  int         init_start [NINIT];
  logic [8:0] rom [NINIT];
  logic [8:0] q [$];
  bit         acc_flag;

  function automatic int lo_of(input logic [8:0] v);
    return (!v[8] && (v[7:0] == 8'h01 || v[7:0] == 8'h02 || v[7:0] == 8'h03)) ? CLR : LO;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    int t;
    for (int i = 0; i < NINIT; i++) begin
      if (i < REPS)          rom[i] = 9'h038;
      else if (i == REPS)    rom[i] = 9'h00F;
      else if (i == REPS+1)  rom[i] = 9'h001;
      else                   rom[i] = 9'h006;
    end
    e = 0;
    q.delete();
    cur_start = -1000;
    cur_val = 9'h000;
    init_i = 0;
    t = PWR;
    for (int i = 0; i < NINIT; i++) begin
      init_start[i] = t;
      t = t + HI + lo_of(rom[i]);
    end
    init_end = t;
    idle_at = init_end;
  endtask

  task automatic check_outputs();
    chk("EN",         32'(EN),         32'((e >= cur_start && e < cur_start + HI) ? 1 : 0));
    chk("RS",         32'(RS),         32'(cur_val[8]));
    chk("data",       32'(data),       32'(cur_val[7:0]));
    chk("RW",         32'(RW),         32'd0);
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("wr_ready",   32'(wr_ready),   32'((q.size() < DEPTH) ? 1 : 0));
    chk("init_done",  32'(init_done),  32'((e >= init_end) ? 1 : 0));
    chk("busy",       32'(busy),       32'((e < idle_at || q.size() > 0) ? 1 : 0));
  endtask

  // One clock: drive at negedge, predict the edge, check at the next negedge.
  task automatic cycle(input bit v, input bit rs, input logic [7:0] d);
    bit pop;
    wr_valid = v;
    wr_rs    = rs;
    wr_data  = d;
    e = e + 1;
    pop = (e > idle_at) && (q.size() > 0);
    acc_flag = v && (q.size() < DEPTH);
    if (pop) begin
      cur_val   = q.pop_front();
      cur_start = e;
      idle_at   = e + HI + lo_of(cur_val);
      $display("edge %0d: write strobe rs=%0d data=%02h queued=%0d", e, cur_val[8], cur_val[7:0], q.size());
    end else if (init_i < NINIT && e == init_start[init_i]) begin
      cur_val   = rom[init_i];
      cur_start = e;
      $display("edge %0d: init strobe %0d data=%02h", e, init_i, cur_val[7:0]);
      init_i++;
    end
    if (acc_flag) q.push_back({rs, d});
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(e >= idle_at && q.size() == 0) && n < limit) begin
      cycle(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_idle: budget of %0d cycles exhausted", limit);
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_EN",         32'(EN),         32'd0);
    chk("rst_RS",         32'(RS),         32'd0);
    chk("rst_data",       32'(data),       32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_init_done",  32'(init_done),  32'd0);
    chk("rst_wr_ready",   32'(wr_ready),   32'd1);
    model_reset();
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bit         rs;
    RST = 1'b1;
    wr_valid = 1'b0;
    wr_rs = 1'b0;
    wr_data = 8'h00;
    model_reset();
    @(negedge CLK);

    // Power-up wait and init sequence with no writes
    apply_reset();
    wait_idle(400);
    run_idle(3);
    chk("init_done_after_init", 32'(init_done), 32'd1);

    // Single character: EN one edge after acceptance
    cycle(1'b1, 1'b1, 8'h2D);
    chk("accept_2D", 32'(acc_flag), 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    chk("lat_EN",   32'(EN),   32'd1);
    chk("lat_RS",   32'(RS),   32'd1);
    chk("lat_data", 32'(data), 32'h2D);
    wait_idle(100);
    run_idle(1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Clear command (long low) versus character 0x01 (normal low)
    cycle(1'b1, 1'b0, 8'h01);
    wait_idle(100);
    cycle(1'b1, 1'b1, 8'h01);
    wait_idle(100);
    cycle(1'b1, 1'b0, 8'h02);
    wait_idle(100);

    // Push on the pop edge with one entry queued
    cycle(1'b1, 1'b1, 8'h40);
    cycle(1'b1, 1'b1, 8'h41);
    chk("push_on_pop_level", 32'(fifo_level), 32'd1);
    wait_idle(200);

    // Randomised traffic, including back-pressure and long-low commands
    for (int i = 0; i < 400; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      cycle($urandom_range(0, 2) == 0, rs, d);
    end
    wait_idle(400);

    // Writes during power-up: five offered, four fit
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h31 + i));
    chk("pwrup_level_full", 32'(fifo_level), 32'd4);
    chk("pwrup_ready_low",  32'(wr_ready),   32'd0);
    wait_idle(600);

    // Reset on the second EN-high cycle of a character write
    cycle(1'b1, 1'b1, 8'h58);
    cycle(1'b1, 1'b1, 8'h59);
    cycle(1'b0, 1'b0, 8'h00);
    chk("pre_rst_EN", 32'(EN), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("async_EN",         32'(EN),         32'd0);
    chk("async_RS",         32'(RS),         32'd0);
    chk("async_data",       32'(data),       32'd0);
    chk("async_fifo_level", 32'(fifo_level), 32'd0);
    @(negedge CLK);
    apply_reset();
    wait_idle(400);
    cycle(1'b1, 1'b1, 8'h30);
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Parametrised HD44780 8-bit LCD interface controller; successor to the calculator display sequencer.
- Runs the power-up wait and the init command sequence autonomously.
- Accepts command/character writes from upstream logic (digit formatter, operator/sign printer) through a valid/ready port into an internal FIFO.
- Generates timed RS/RW/EN/data bus cycles to the panel.
- Upstream never handles LCD timing.

Parameters:
PWRUP_CYC, 2250000, cycles of idle bus after reset before the first init command
EN_HIGH_CYC, 125000, cycles EN is held high per bus write
EN_LOW_CYC, 250000, cycles EN is held low after each write (normal commands and characters)
CLR_LOW_CYC, 250000, EN-low cycles after a clear (0x01) or home (0x02/0x03) command with RS=0
FUNCSET_REPS, 4, number of 0x38 function-set repetitions in init
FIFO_DEPTH, 16, write FIFO entries (power of two, >=2)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
wr_valid  in  1  upstream write request
wr_ready  out  1  FIFO not full; a write is accepted on a CLK edge where wr_valid & wr_ready
wr_rs  in  1  0 = command, 1 = character data
wr_data  in  8  command or ASCII code
init_done  out  1  high once the init sequence has finished
busy  out  1  high when not in IDLE or the FIFO is non-empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
RS  out  1  LCD register select
RW  out  1  LCD read/write; tied 0 (write only)
EN  out  1  LCD enable strobe
data  out  8  LCD data bus

Behaviour:
- Reset (async, immediate): RS=0, RW=0, EN=0, data=0x00, init_done=0, FIFO flushed (fifo_level=0), state=PWRUP, counters=0. Reset mid-strobe drops EN at once; after release the full sequence restarts.
- States: PWRUP, INIT_HI, INIT_LO, IDLE, WR_HI, WR_LO.
- PWRUP: EN=0 for PWRUP_CYC cycles, then -> INIT_HI with index 0.
- Init ROM, all RS=0, in order: 0x38 repeated FUNCSET_REPS times, then 0x0F, 0x01, 0x06.
- INIT_HI: on entry edge, data and RS load and EN goes 1; EN stays high for EN_HIGH_CYC cycles, then -> INIT_LO.
- INIT_LO: EN=0; data/RS are held stable. Duration is CLR_LOW_CYC for 0x01, else EN_LOW_CYC. Then the next index goes to INIT_HI, or after the last entry -> IDLE with init_done=1. init_done is sticky until reset.
- IDLE: if FIFO is non-empty, pop on this edge, load data/RS/EN=1, -> WR_HI. Otherwise hold outputs with EN=0.
- Latency: in IDLE with an empty FIFO, a write accepted at edge k gives EN=1 at edge k+1.
- WR_HI / WR_LO: same timing as INIT_HI / INIT_LO. The long low phase applies when RS=0 and data is 0x01, 0x02 or 0x03. WR_LO -> IDLE.
- Writes may be accepted at any time, including during PWRUP/init. They are queued and issued after init in FIFO order.
- wr_ready = !full, computed from registered occupancy.
  - When full, a write is refused even on a cycle where a pop occurs.
  - Push and pop on the same edge leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- EN high and low phases are each at least 1 cycle. A parameter of 0 is illegal: elaboration-time error.
- Counters are 32-bit unsigned. Terminal compare is count == PARAM-1, then reset to 0. No overflow is possible within legal parameters.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - the command constants LCD_FUNCSET_8B2L=0x38, LCD_DISP_ON_CUR_BLINK=0x0F, LCD_CLEAR=0x01, LCD_ENTRY_INC=0x06;
  - the character constants CHR_SPACE=0x20, CHR_MINUS=0x2D, CHR_PLUS=0x2B, CHR_DIGIT0=0x30 for upstream formatters.
- Sub-module lcd_wr_fifo is a synchronous 9-bit-wide FIFO ({rs,data}) with async reset, push/pop/full/empty/level.
- The FSM and timers stay in the top module.

Test Plan:
Common parameters: PWRUP_CYC=20, EN_HIGH_CYC=4, EN_LOW_CYC=8, CLR_LOW_CYC=16, FUNCSET_REPS=4, FIFO_DEPTH=4.
1. Release RST, no writes -> EN=0 for 20 cycles. Then 7 strobes with RS=0, data 38,38,38,38,0F,01,06, each EN high 4 cycles. Low phase is 16 after 0x01, 8 otherwise. init_done rises after the final low phase; RW=0 throughout.
2. After init_done, single write rs=1 data=0x2D -> EN=1 exactly one edge after acceptance with RS=1, data=0x2D. EN high 4 cycles, low 8, then IDLE with busy=0.
3. During PWRUP, 5 consecutive writes 0x31..0x35 -> first 4 accepted, fifo_level=4, wr_ready=0 on the 5th. After init, 0x31,0x32,0x33,0x34 are strobed in order.
4. After init, write rs=0 data=0x01 -> low phase lasts 16 cycles. The same with rs=1 data=0x01 -> 8 cycles.
5. Assert RST on the 2nd EN-high cycle of a character write -> EN, RS and data go 0 without waiting for CLK, fifo_level=0. After release, PWRUP restarts (20 idle cycles).
6. fifo_level=1 in IDLE, push 0x41 on the pop edge -> fifo_level stays 1, and 0x41 is issued after the popped entry.
